fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory. It owns the fetch PC, drives the memory's strobe/acknowledge request port, buffers returned instruction words with their PCs in a small FIFO, and presents them to decode through a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch at the new PC. Misaligned redirect targets are trapped and raise a fault.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's external signals: the instruction-memory
// strobe/acknowledge port, the execute-stage redirect input and the decode
// valid/ready handshake.
//   master : used by fetch_unit (drives o_* signals, samples i_* signals)
//   slave  : used by the environment (memory, execute, decode)
interface fetch_unit_if;
  logic [31:0] o_imem_addr;
  logic        o_imem_stb;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_fault;

  modport master (
    output o_imem_addr, o_imem_stb,
    input  i_imem_ack, i_imem_data,
    input  i_redirect, i_redirect_pc,
    output o_valid,
    input  i_ready,
    output o_instr, o_pc, o_fault
  );

  modport slave (
    input  o_imem_addr, o_imem_stb,
    output i_imem_ack, i_imem_data,
    output i_redirect, i_redirect_pc,
    input  o_valid,
    output i_ready,
    input  o_instr, o_pc, o_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, requests words from instruction
// memory with a strobe/acknowledge port, buffers {pc, instr} pairs in a small
// FIFO and hands them to decode through a valid/ready handshake. A redirect
// flushes the FIFO and restarts fetch; a misaligned redirect target parks the
// stage in a fault state until an aligned redirect arrives.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : fetch_unit_if.master (imem request, redirect, decode handshake, fault)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [31:0]   fpc;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic stb, valid, push, pop, aligned;

  // stb depends only on registered state, so redirect/ready cannot reach it
  // combinationally.
  always_comb begin
    stb     = (state == RUN) && (count < FULL);
    valid   = (state == RUN) && (count != '0);
    push    = stb && bus.i_imem_ack;
    pop     = valid && bus.i_ready;
    aligned = (bus.i_redirect_pc[1:0] == 2'b00);
  end

  always_comb begin
    state_next = state;
    if (bus.i_redirect) begin
      state_next = aligned ? RUN : FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Redirect discards any same-cycle capture or pop: pointers and count
  // simply restart from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.i_redirect) begin
      fpc    <= bus.i_redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fpc;
      fifo_instr[wr_ptr] <= bus.i_imem_data;
    end
  end

  // Outputs are forced to their idle values while reset is held so they are
  // defined even before the first reset edge.
  always_comb begin
    bus.o_imem_stb  = rst_n && stb;
    bus.o_imem_addr = rst_n ? fpc : RESET_PC;
    bus.o_valid     = rst_n && valid;
    bus.o_fault     = rst_n && (state == FAULT);
    bus.o_instr     = '0;
    bus.o_pc        = '0;
    if (rst_n && (count != '0)) begin
      bus.o_instr = fifo_instr[rd_ptr];
      bus.o_pc    = fifo_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Memory is a function of the address;
// every instruction accepted by decode must be the next PC in program order
// from the last reset/redirect target, carrying that PC's memory word.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEP    = 2;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] obs[$];
  logic [31:0] exp_next;
  int          ack_mode;
  int          wcnt;
  logic        last_stb, last_ack, last_redirect, last_rst;
  logic [31:0] last_addr;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'd0) return 32'h11;
    if (a == 32'd4) return 32'h22;
    if (a == 32'd8) return 32'h33;
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: play memory, record the decode handshake seen before
  // the edge, then step to just after the edge.
  task automatic tick();
    logic a;
    last_stb      = bus.o_imem_stb;
    last_addr     = bus.o_imem_addr;
    last_redirect = bus.i_redirect;
    last_rst      = rst_n;
    case (ack_mode)
      0: a = 1'b1;
      1: begin
        a = 1'b0;
        if (bus.o_imem_stb) begin
          if (wcnt == 2) begin a = 1'b1; wcnt = 0; end
          else wcnt++;
        end
      end
      default: a = 1'($urandom_range(0, 1));
    endcase
    bus.i_imem_ack  = a;
    bus.i_imem_data = bus.o_imem_stb ? word(bus.o_imem_addr) : $urandom();
    last_ack = a;
    #3;
    if (rst_n && !bus.i_redirect && bus.o_valid && bus.i_ready)
      obs.push_back({bus.o_pc, bus.o_instr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.i_ready = 1'b1; bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0; bus.i_imem_ack = 1'b0; bus.i_imem_data = '0;
    ack_mode = 0; wcnt = 0;
    #1;
    checks++; if (bus.o_imem_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", bus.o_imem_stb); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", bus.o_imem_addr, RST_PC); end
    tick(); tick();
    checks++; if (bus.o_instr !== 32'h0 || bus.o_pc !== 32'h0) begin errors++; $display("FAIL rst_head: got pc=%h instr=%h expected 0/0", bus.o_pc, bus.o_instr); end
    checks++; if (bus.o_imem_stb !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_held: got stb=%b valid=%b expected 0/0", bus.o_imem_stb, bus.o_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== RST_PC) begin errors++; $display("FAIL rst_release: got stb=%b addr=%h expected 1/%h", bus.o_imem_stb, bus.o_imem_addr, RST_PC); end
    checks++; if (bus.o_valid !== 1'b0 || bus.o_fault !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got valid=%b fault=%b expected 0/0", bus.o_valid, bus.o_fault); end
    exp_next = RST_PC;
  endtask

  task automatic test_stream();
    logic [63:0] e;
    logic [31:0] prev;
    ack_mode = 0; bus.i_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'(4 * i) || bus.o_instr !== 32'(8'h11 * (i + 1))) begin
        errors++; $display("FAIL stream_first: got valid=%b pc=%h instr=%h expected 1/%h/%h",
                           bus.o_valid, bus.o_pc, bus.o_instr, 32'(4 * i), 32'(8'h11 * (i + 1)));
      end
    end
    prev = bus.o_pc;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_pc !== prev + 32'd4) begin
        errors++; $display("FAIL throughput: got valid=%b pc=%h expected 1/%h", bus.o_valid, bus.o_pc, prev + 32'd4);
      end
      prev = prev + 32'd4;
    end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL stream_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    logic [31:0] p;
    p = exp_next;
    checks++; if (bus.o_pc !== p) begin errors++; $display("FAIL bp_head: got %h expected %h", bus.o_pc, p); end
    bus.i_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
    checks++; if (bus.o_imem_stb !== 1'b0 || bus.o_imem_addr !== p + 32'd4 * DEP) begin errors++; $display("FAIL bp_full: got stb=%b addr=%h expected 0/%h", bus.o_imem_stb, bus.o_imem_addr, p + 32'd4 * DEP); end
    checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== p) begin errors++; $display("FAIL bp_hold: got valid=%b pc=%h expected 1/%h", bus.o_valid, bus.o_pc, p); end
    bus.i_ready = 1'b1;
    tick();
    checks++; if (bus.o_imem_stb !== 1'b1) begin errors++; $display("FAIL bp_reopen: got stb=%b expected 1", bus.o_imem_stb); end
    for (int unsigned i = 0; i < 6; i++) tick();
    checks++; if (obs.size() != 7) begin errors++; $display("FAIL bp_count: got %0d deliveries expected 7", obs.size()); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL bp_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
  endtask

  task automatic test_slow_ack();
    logic [63:0] e;
    int unsigned n = 0;
    ack_mode = 1; wcnt = 0; bus.i_ready = 1'b1;
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      if (last_stb && !last_ack) begin
        checks++;
        if (bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== last_addr) begin errors++; $display("FAIL wait_stable: got stb=%b addr=%h expected 1/%h", bus.o_imem_stb, bus.o_imem_addr, last_addr); end
      end else if (last_stb && last_ack) begin
        checks++;
        if (bus.o_imem_addr !== last_addr + 32'd4) begin errors++; $display("FAIL ack_advance: got addr=%h expected %h", bus.o_imem_addr, last_addr + 32'd4); end
      end
    end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++; n++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL slow_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
    checks++; if (n < 8) begin errors++; $display("FAIL slow_progress: got %0d deliveries expected at least 8", n); end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    ack_mode = 0;
    bus.i_ready = 1'b0;
    tick();
    checks++; if (bus.o_imem_stb !== 1'b0) begin errors++; $display("FAIL redir_prefull: got stb=%b expected 0", bus.o_imem_stb); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h100;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== 32'h100) begin errors++; $display("FAIL redir_flush: got valid=%b stb=%b addr=%h expected 0/1/00000100", bus.o_valid, bus.o_imem_stb, bus.o_imem_addr); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL redir_pre_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
    exp_next = 32'h100;
    bus.i_ready = 1'b1;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h100 || bus.o_instr !== word(32'h100)) begin errors++; $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 1/00000100/%h", bus.o_valid, bus.o_pc, bus.o_instr, word(32'h100)); end
    tick();
    checks++; if (bus.o_pc !== 32'h104) begin errors++; $display("FAIL redir_second: got pc=%h expected 00000104", bus.o_pc); end
    // Redirect while streaming: same-cycle ack and pop are both discarded.
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL redir_stream: got valid=%b addr=%h expected 0/fffffff8", bus.o_valid, bus.o_imem_addr); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL redir_mid_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
    exp_next = 32'hFFFF_FFF8;
    for (int unsigned i = 0; i < 6; i++) tick();
    checks++; if (obs.size() != 5) begin errors++; $display("FAIL wrap_count: got %0d deliveries expected 5", obs.size()); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL wrap_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
  endtask

  task automatic test_fault();
    logic [63:0] e;
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL fault_pre_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h102;
    tick();
    bus.i_redirect = 1'b0;
    ack_mode = 2;
    for (int unsigned i = 0; i < 6; i++) begin
      checks++;
      if (bus.o_fault !== 1'b1 || bus.o_imem_stb !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL fault_state: got fault=%b stb=%b valid=%b expected 1/0/0", bus.o_fault, bus.o_imem_stb, bus.o_valid); end
      tick();
    end
    checks++; if (obs.size() != 0) begin errors++; $display("FAIL fault_leak: got %0d deliveries expected 0", obs.size()); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h200;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_fault !== 1'b0 || bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== 32'h200) begin errors++; $display("FAIL fault_clear: got fault=%b stb=%b addr=%h expected 0/1/00000200", bus.o_fault, bus.o_imem_stb, bus.o_imem_addr); end
    exp_next = 32'h200;
    ack_mode = 0;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h200) begin errors++; $display("FAIL fault_resume: got valid=%b pc=%h expected 1/00000200", bus.o_valid, bus.o_pc); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    ack_mode = 0; bus.i_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) tick();
    checks++; if (bus.o_imem_stb !== 1'b0 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got stb=%b valid=%b expected 0/1", bus.o_imem_stb, bus.o_valid); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL mid_pre_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
    rst_n = 1'b0; bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h300;
    tick();
    checks++; if (bus.o_valid !== 1'b0 || bus.o_imem_stb !== 1'b0 || bus.o_imem_addr !== RST_PC || bus.o_pc !== 32'h0) begin errors++; $display("FAIL mid_reset: got valid=%b stb=%b addr=%h pc=%h expected 0/0/%h/0", bus.o_valid, bus.o_imem_stb, bus.o_imem_addr, bus.o_pc, RST_PC); end
    rst_n = 1'b1; bus.i_redirect = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== RST_PC) begin errors++; $display("FAIL mid_restart: got valid=%b stb=%b addr=%h expected 0/1/%h", bus.o_valid, bus.o_imem_stb, bus.o_imem_addr, RST_PC); end
    exp_next = RST_PC;
    bus.i_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) tick();
    checks++; if (obs.size() != 3) begin errors++; $display("FAIL mid_count: got %0d deliveries expected 3", obs.size()); end
    while (obs.size() > 0) begin
      e = obs.pop_front(); checks++;
      if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL mid_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
      exp_next += 32'd4;
    end
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic        fault_m = 1'b0;
    logic [31:0] rpc;
    int unsigned n = 0;
    ack_mode = 2;
    for (int unsigned i = 0; i < 500; i++) begin
      bus.i_ready = 1'($urandom_range(0, 1));
      bus.i_redirect = ($urandom_range(0, 24) == 0);
      rpc = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      bus.i_redirect_pc = rpc;
      tick();
      while (obs.size() > 0) begin
        e = obs.pop_front(); checks++; n++;
        if (e !== {exp_next, word(exp_next)}) begin errors++; $display("FAIL rand_order: got pc=%h instr=%h expected pc=%h instr=%h", e[63:32], e[31:0], exp_next, word(exp_next)); end
        exp_next += 32'd4;
      end
      if (last_redirect) begin
        fault_m  = (rpc[1:0] != 2'b00);
        exp_next = rpc;
      end else if (last_stb && !last_ack) begin
        checks++;
        if (bus.o_imem_stb !== 1'b1 || bus.o_imem_addr !== last_addr) begin errors++; $display("FAIL rand_wait_stable: got stb=%b addr=%h expected 1/%h", bus.o_imem_stb, bus.o_imem_addr, last_addr); end
      end
      bus.i_redirect = 1'b0;
      checks++;
      if (bus.o_fault !== fault_m) begin errors++; $display("FAIL rand_fault: got %b expected %b", bus.o_fault, fault_m); end
      if (fault_m) begin
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_imem_stb !== 1'b0) begin errors++; $display("FAIL rand_fault_quiet: got valid=%b stb=%b expected 0/0", bus.o_valid, bus.o_imem_stb); end
      end
    end
    checks++; if (n < 50) begin errors++; $display("FAIL rand_progress: got %0d deliveries expected at least 50", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_ack();
    test_redirect();
    test_fault();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
